uart_tx_arbiter: RTL and testbench

//  Shares one UartTx serializer among N_REQ byte requesters with round-robin fairness.

---
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : round-robin sharing of one UartTx serializer among N_REQ byte
//             requesters; one byte per tx_we pulse, one-cycle ack per launch.
//  Options  : UART_ARB_HDR_EN - each grant sends a header frame (8'hA0|id)
//             before the requester's data frame.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic               CLK,
  input  logic               RST_X,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ack,
  output logic [7:0]         tx_data,
  output logic               tx_we,
  input  logic               tx_ready,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy
);

`ifdef UART_ARB_HDR_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GUARD = 2'd2,
    S_WAIT  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUARD = 2'd2,
    S_WAIT  = 2'd3
  } state_t;
`endif

  state_t             state_q,    state_d;
  logic [ID_W-1:0]    rr_ptr_q,   rr_ptr_d;
  logic [N_REQ-1:0]   req_ack_q,  req_ack_d;
  logic [7:0]         tx_data_q,  tx_data_d;
  logic               tx_we_q,    tx_we_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               busy_q,     busy_d;
`ifdef UART_ARB_HDR_EN
  logic               hdr_q,      hdr_d;
`endif

  logic [ID_W-1:0]    sel;
  logic [ID_W-1:0]    idx;
  logic               found;

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    req_ack_d  = '0;
    tx_data_d  = tx_data_q;
    tx_we_d    = 1'b0;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
`ifdef UART_ARB_HDR_EN
    hdr_d      = hdr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tx_ready && found) begin
          tx_we_d    = 1'b1;
          grant_id_d = sel;
          rr_ptr_d   = sel;
          busy_d     = 1'b1;
          state_d    = S_GUARD;
`ifdef UART_ARB_HDR_EN
          tx_data_d  = 8'hA0 | {{(8-ID_W){1'b0}}, sel};
          hdr_d      = 1'b1;
`else
          tx_data_d  = req_data[{sel, 3'b000} +: 8];
          req_ack_d  = {{(N_REQ-1){1'b0}}, 1'b1} << sel;
`endif
        end
      end
`ifdef UART_ARB_HDR_EN
      S_ISSUE: begin
        tx_data_d = req_data[{grant_id_q, 3'b000} +: 8];
        tx_we_d   = 1'b1;
        req_ack_d = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id_q;
        state_d   = S_GUARD;
      end
`endif
      // UartTx ready still reflects the pre-launch state here.
      S_GUARD: state_d = S_WAIT;
      S_WAIT: begin
        if (tx_ready) begin
`ifdef UART_ARB_HDR_EN
          if (hdr_q) begin
            hdr_d   = 1'b0;
            state_d = S_ISSUE;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
`else
          busy_d  = 1'b0;
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= ID_W'(N_REQ - 1);
      req_ack_q  <= '0;
      tx_data_q  <= 8'h00;
      tx_we_q    <= 1'b0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
`ifdef UART_ARB_HDR_EN
      hdr_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      req_ack_q  <= req_ack_d;
      tx_data_q  <= tx_data_d;
      tx_we_q    <= tx_we_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
`ifdef UART_ARB_HDR_EN
      hdr_q      <= hdr_d;
`endif
    end
  end

  assign req_ack  = req_ack_q;
  assign tx_data  = tx_data_q;
  assign tx_we    = tx_we_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural serializer that drops
// tx_ready for FRAME cycles after each tx_we and logs every launched byte.
`default_nettype none

module tb_uart_tx_arbiter;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int FRAME = 10;

  logic        CLK = 1'b0;
  logic        RST_X;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic [7:0]  tx_data;
  logic        tx_we;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        busy;

  uart_tx_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .CLK       (CLK),
    .RST_X     (RST_X),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .tx_data   (tx_data),
    .tx_we     (tx_we),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          pend[4];
  logic [7:0]  dat[4];
  logic [7:0]  rxq[$];
  logic [3:0]  ackq[$];
  logic [1:0]  gidq[$];
  int          viol    = 0;
  int          ser_cnt = 0;
  bit          hold    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive_req();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]       = (pend[i] != 0);
      req_data[8*i +: 8] = dat[i];
    end
  endtask

  // One clock: observe DUT at the falling edge, then update requesters and serializer.
  task automatic cyc();
    @(negedge CLK);
    if (tx_we) begin
      if (!tx_ready) viol++;
      rxq.push_back(tx_data);
      ackq.push_back(req_ack);
      gidq.push_back(grant_id);
      if (req_ack != 4'd0 && req_ack != (4'd1 << grant_id)) viol++;
`ifndef UART_ARB_HDR_EN
      if (req_ack == 4'd0) viol++;
`endif
    end else if (req_ack != 4'd0) begin
      viol++;
    end
    for (int i = 0; i < 4; i++)
      if (req_ack[i] && pend[i] > 0) pend[i]--;
    if (tx_we) ser_cnt = FRAME;
    else if (ser_cnt > 0) ser_cnt--;
    tx_ready = !hold && (ser_cnt == 0);
    drive_req();
  endtask

  task automatic wait_we(input int budget, output int lat);
    int n0;
    n0  = rxq.size();
    lat = 0;
    while (rxq.size() == n0 && lat < budget) begin
      cyc();
      lat++;
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c;
    c = 0;
    while ((busy || !tx_ready || pend[0] != 0 || pend[1] != 0 ||
            pend[2] != 0 || pend[3] != 0) && c < budget) begin
      cyc();
      c++;
    end
    check(tag, {31'd0, c < budget}, 32'd1);
  endtask

  task automatic do_reset();
    RST_X = 1'b0;
    repeat (2) cyc();
    RST_X = 1'b1;
    cyc();
  endtask

  task automatic clear_log();
    rxq.delete();
    ackq.delete();
    gidq.delete();
  endtask

  initial begin
    int lat;
    int bz;
    RST_X    = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pend[i] = 0;
      dat[i]  = 8'h00;
    end
    drive_req();
    repeat (3) cyc();
    check("rst_ack",   {28'd0, req_ack},  32'h0);
    check("rst_we",    {31'd0, tx_we},    32'h0);
    check("rst_data",  {24'd0, tx_data},  32'h0);
    check("rst_gid",   {30'd0, grant_id}, 32'h0);
    check("rst_busy",  {31'd0, busy},     32'h0);
    RST_X = 1'b1;
    cyc();

`ifndef UART_ARB_HDR_EN
    // T1 single requester
    pend[0] = 1; dat[0] = 8'h61; drive_req();
    wait_we(20, lat);
    check("t1_lat",  lat,                1);
    check("t1_data", {24'd0, tx_data},  32'h61);
    check("t1_ack",  {28'd0, req_ack},  32'h1);
    check("t1_gid",  {30'd0, grant_id}, 32'h0);
    check("t1_busy", {31'd0, busy},     32'h1);
    wait_done("t1_done", 100);
    check("t1_rx",   {24'd0, rxq[0]},   32'h61);

    // T2 fairness from reset pointer
    do_reset();
    clear_log();
    for (int i = 0; i < 4; i++) begin
      pend[i] = 2;
      dat[i]  = 8'h10 + 8'(i);
    end
    drive_req();
    wait_done("t2_done", 400);
    check("t2_cnt",  rxq.size(), 8);
    check("t2_rx0",  {24'd0, rxq[0]}, 32'h10);
    check("t2_rx1",  {24'd0, rxq[1]}, 32'h11);
    check("t2_rx2",  {24'd0, rxq[2]}, 32'h12);
    check("t2_rx3",  {24'd0, rxq[3]}, 32'h13);
    check("t2_rx4",  {24'd0, rxq[4]}, 32'h10);
    check("t2_ack7", {28'd0, ackq[7]}, 32'h8);

    // T3 hold-off while serializer is not ready
    clear_log();
    hold = 1'b1; tx_ready = 1'b0;
    pend[2] = 1; dat[2] = 8'h22; drive_req();
    repeat (50) cyc();
    check("t3_no_we", rxq.size(), 0);
    hold = 1'b0; tx_ready = 1'b1;
    wait_we(20, lat);
    check("t3_lat",  lat,                1);
    check("t3_gid",  {30'd0, grant_id}, 32'h2);
    check("t3_ack",  {28'd0, req_ack},  32'h4);
    wait_done("t3_done", 100);

    // T4 pointer wrap after a grant to requester 3
    pend[3] = 1; dat[3] = 8'h43; drive_req();
    wait_done("t4a_done", 100);
    clear_log();
    pend[0] = 1; dat[0] = 8'h40;
    pend[3] = 1; drive_req();
    wait_done("t4b_done", 200);
    check("t4_gid0", {30'd0, gidq[0]}, 32'h0);
    check("t4_gid1", {30'd0, gidq[1]}, 32'h3);
    check("t4_rx1",  {24'd0, rxq[1]},  32'h43);

    // T5 asynchronous reset while a frame is in flight
    pend[1] = 1; dat[1] = 8'h51; drive_req();
    wait_we(20, lat);
    repeat (3) cyc();
    RST_X = 1'b0;
    #1;
    check("t5_busy", {31'd0, busy},     32'h0);
    check("t5_we",   {31'd0, tx_we},    32'h0);
    check("t5_gid",  {30'd0, grant_id}, 32'h0);
    check("t5_data", {24'd0, tx_data},  32'h0);
    clear_log();
    pend[0] = 1; dat[0] = 8'h50;
    pend[2] = 1; dat[2] = 8'h52; drive_req();
    repeat (2) cyc();
    check("t5_ser_busy", {31'd0, tx_ready}, 32'h0);
    RST_X = 1'b1;
    wait_done("t5_done", 200);
    check("t5_rx0", {24'd0, rxq[0]}, 32'h50);
    check("t5_rx1", {24'd0, rxq[1]}, 32'h52);
`else
    // T6 header + data per grant
    clear_log();
    pend[1] = 1; dat[1] = 8'h55; drive_req();
    wait_we(20, lat);
    check("t6_lat", lat, 1);
    bz = 0;
    lat = 0;
    while (rxq.size() < 2 && lat < 100) begin
      cyc();
      lat++;
      if (!busy) bz++;
    end
    check("t6_busy_gap", bz, 0);
    wait_done("t6_done", 100);
    check("t6_cnt",  rxq.size(), 2);
    check("t6_hdr",  {24'd0, rxq[0]},  32'hA1);
    check("t6_dat",  {24'd0, rxq[1]},  32'h55);
    check("t6_ack0", {28'd0, ackq[0]}, 32'h0);
    check("t6_ack1", {28'd0, ackq[1]}, 32'h2);
`endif

    check("protocol_viol", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
